// File: rtl/tx_packet_scheduler.sv
// Frames one source's message (DD, src, dest, len, payload, CRC-8) onto the UART tx; TX_RR_ARB_EN selects round-robin over fixed priority.
// Latency: first byte (prefix) is presented one cycle after a request is seen in IDLE.
// Backpressure: tx_valid/tx_ready; tx_data and the source pop are held until tx_ready.
`ifndef NUM_SOURCES
`define NUM_SOURCES 4
`endif

module tx_packet_scheduler #(
    parameter int         NUM_SOURCES = `NUM_SOURCES,
    parameter logic [7:0] PREFIX      = 8'hDD,
    parameter logic [7:0] SRC_BASE    = 8'h01,
    parameter logic [7:0] DEST_ADDR   = 8'h00
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_SOURCES-1:0]   have_msg_bus,
    input  logic [8*NUM_SOURCES-1:0] len_bus,
    input  logic [8*NUM_SOURCES-1:0] data_bus,
    output logic [NUM_SOURCES-1:0]   rdreq_bus,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [2:0]               current_source,
    output logic [2:0]               state,
    output logic [7:0]               crc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFIX  = 3'd1,
        S_SRC     = 3'd2,
        S_DEST    = 3'd3,
        S_LEN     = 3'd4,
        S_PAYLOAD = 3'd5,
        S_CRC     = 3'd6
    } state_t;

    localparam logic [3:0] NS4 = 4'(NUM_SOURCES);

    state_t     st, st_nxt;
    logic [2:0] cur, cur_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] crc_q, crc_nxt;
    logic       xfer;
    logic       any_req;
    logic [2:0] winner;
    logic [2:0] start_idx;
    logic [2:0] cand;
    logic [3:0] sum;
    logic [7:0] req8;
    logic [7:0] len_arr  [8];
    logic [7:0] data_arr [8];

    // Padding to eight entries lets a 3-bit index select without width games.
    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NUM_SOURCES) begin : g_real
            assign len_arr[g]  = len_bus[8*g +: 8];
            assign data_arr[g] = data_bus[8*g +: 8];
        end else begin : g_pad
            assign len_arr[g]  = 8'h00;
            assign data_arr[g] = 8'h00;
        end
    end

    assign req8 = 8'(have_msg_bus);
    assign xfer = tx_valid && tx_ready;

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int b = 0; b < 8; b++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

`ifdef TX_RR_ARB_EN
    logic [2:0] rr_ptr;
    assign start_idx = rr_ptr;

    // rr_ptr holds the index where the next search begins.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr <= 3'd0;
        end else if (st == S_IDLE && any_req) begin
            rr_ptr <= (({1'b0, winner} + 4'd1) >= NS4) ? 3'd0 : winner + 3'd1;
        end
    end
`else
    assign start_idx = 3'd0;
`endif

    always_comb begin
        any_req = 1'b0;
        winner  = 3'd0;
        cand    = 3'd0;
        sum     = 4'd0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            sum  = {1'b0, start_idx} + 4'(k);
            cand = (sum >= NS4) ? 3'(sum - NS4) : sum[2:0];
            if (!any_req && req8[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (st)
            S_PREFIX:  tx_data = PREFIX;
            S_SRC:     tx_data = SRC_BASE + {5'd0, cur};
            S_DEST:    tx_data = DEST_ADDR;
            S_LEN:     tx_data = cnt;
            S_PAYLOAD: tx_data = data_arr[cur];
            S_CRC:     tx_data = crc_q;
            default:   tx_data = 8'h00;
        endcase
    end

    always_comb begin
        st_nxt  = st;
        cur_nxt = cur;
        cnt_nxt = cnt;
        crc_nxt = crc_q;
        case (st)
            S_IDLE: if (any_req) begin
                st_nxt  = S_PREFIX;
                cur_nxt = winner;
                cnt_nxt = len_arr[winner];
                crc_nxt = 8'h00;
            end
            S_PREFIX: if (xfer) st_nxt = S_SRC;
            S_SRC: if (xfer) begin
                st_nxt  = S_DEST;
                crc_nxt = crc8_upd(crc_q, tx_data);
            end
            S_DEST: if (xfer) begin
                st_nxt  = S_LEN;
                crc_nxt = crc8_upd(crc_q, tx_data);
            end
            S_LEN: if (xfer) begin
                st_nxt  = (cnt == 8'd0) ? S_CRC : S_PAYLOAD;
                crc_nxt = crc8_upd(crc_q, tx_data);
            end
            S_PAYLOAD: if (xfer) begin
                cnt_nxt = cnt - 8'd1;
                crc_nxt = crc8_upd(crc_q, tx_data);
                if (cnt == 8'd1) st_nxt = S_CRC;
            end
            S_CRC: if (xfer) st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st    <= S_IDLE;
            cur   <= 3'd0;
            cnt   <= 8'd0;
            crc_q <= 8'h00;
        end else begin
            st    <= st_nxt;
            cur   <= cur_nxt;
            cnt   <= cnt_nxt;
            crc_q <= crc_nxt;
        end
    end

    // Pop is tied to the accepted payload byte so the head advances exactly once per byte.
    always_comb begin
        rdreq_bus = '0;
        if (st == S_PAYLOAD && xfer) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                rdreq_bus[i] = (3'(i) == cur);
            end
        end
    end

    assign tx_valid       = (st != S_IDLE);
    assign current_source = cur;
    assign state          = st;
    assign crc            = crc_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Bench for tx_packet_scheduler: table rows, hand sequences and random traffic against a frame-level model.
module tb_tx_packet_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [N-1:0]   have_msg_bus;
    logic [8*N-1:0] len_bus;
    logic [8*N-1:0] data_bus;
    logic [N-1:0]   rdreq_bus;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [2:0]     current_source;
    logic [2:0]     state;
    logic [7:0]     crc;

    tx_packet_scheduler #(.NUM_SOURCES(N)) dut (
        .clk(clk), .n_rst(n_rst), .have_msg_bus(have_msg_bus), .len_bus(len_bus),
        .data_bus(data_bus), .rdreq_bus(rdreq_bus), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .current_source(current_source), .state(state), .crc(crc)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Source FIFO model: per-source message lengths and payload bytes.
    int         q_len [N][$];
    logic [7:0] q_pay [N][$];

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int exp_frames, exp_rd, mdl_ptr;
    int fidx, flen, fsrc, frames_done, rd_cnt, rmode;
    int st_log[$];
    int grants[$];
    int last_st;
    bit hold_pend, post_crc;
    logic [7:0] hold_dat;

    typedef struct {
        int         src;
        int         len;
        logic [7:0] b0;
        int         rmode;
        logic [7:0] exp_crc;
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic budget_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget exhausted", nm);
    endtask

    // Bit-serial CRC-8 (x^8+x^2+x+1), message shifted in MSB first.
    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            have_msg_bus[i]   = (q_len[i].size() > 0);
            len_bus[8*i +: 8] = (q_len[i].size() > 0) ? 8'(q_len[i][0]) : 8'h00;
            data_bus[8*i +: 8] = (q_pay[i].size() > 0) ? q_pay[i][0] : 8'h00;
        end
    endtask

    task automatic clear_mon();
        rx_q.delete(); st_log.delete(); grants.delete();
        fidx = 0; flen = 0; fsrc = 0; frames_done = 0; rd_cnt = 0;
        last_st = 0; hold_pend = 0; post_crc = 0;
    endtask

    task automatic flush_sources();
        for (int i = 0; i < N; i++) begin
            q_len[i].delete();
            q_pay[i].delete();
        end
    endtask

    task automatic load_msg(input int src, input int len, input logic [7:0] b0, input bit rnd);
        q_len[src].push_back(len);
        for (int i = 0; i < len; i++)
            q_pay[src].push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(b0 + 8'(i)));
    endtask

    // Whole-run expectation: serve queued messages by policy, one complete frame each.
    task automatic build_expected();
        int cl[N][$];
        logic [7:0] cp[N][$];
        int w, idx, L;
        logic [7:0] c, b;
        bit done;
        for (int i = 0; i < N; i++) begin
            cl[i] = q_len[i];
            cp[i] = q_pay[i];
        end
        exp_q.delete(); exp_frames = 0; exp_rd = 0; done = 0;
        while (!done) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
`ifdef TX_RR_ARB_EN
                idx = (mdl_ptr + k) % N;
`else
                idx = k;
`endif
                if (w < 0 && cl[idx].size() > 0) w = idx;
            end
            if (w < 0) begin
                done = 1;
            end else begin
`ifdef TX_RR_ARB_EN
                mdl_ptr = (w + 1) % N;
`endif
                L = cl[w].pop_front();
                exp_q.push_back(8'hDD);
                c = 8'h00;
                for (int j = 0; j < 3; j++) begin
                    b = (j == 0) ? 8'(w + 1) : (j == 1) ? 8'h00 : 8'(L);
                    exp_q.push_back(b);
                    c = crc_ref(c, b);
                end
                for (int j = 0; j < L; j++) begin
                    b = cp[w].pop_front();
                    exp_q.push_back(b);
                    c = crc_ref(c, b);
                end
                exp_q.push_back(c);
                exp_frames++;
                exp_rd += L;
            end
        end
    endtask

    task automatic cycle();
        logic v, r;
        logic [7:0] d;
        logic [N-1:0] rq;
        logic [2:0] st;
        @(negedge clk);
        v = tx_valid; r = tx_ready; d = tx_data; rq = rdreq_bus; st = state;
        if (hold_pend) begin
            chk("hold_valid", int'(v), 1);
            chk("hold_data", int'(d), int'(hold_dat));
        end
        hold_pend = v && !r;
        hold_dat  = d;
        if (post_crc) chk("idle_after_crc", int'(st), 0);
        post_crc = v && r && (st == 3'd6);
        if (rq != '0) begin
            rd_cnt++;
            chk("rdreq_onehot", int'(rq), 1 << fsrc);
            chk("rdreq_context", (int'(st) << 2) | (int'(v) << 1) | int'(r), (5 << 2) | 3);
        end
        if (int'(st) != last_st) begin
            st_log.push_back(int'(st));
            last_st = int'(st);
        end
        @(posedge clk);
        #1;
        if (v && r) begin
            rx_q.push_back(d);
            if (fidx == 1) fsrc = int'(d) - 1;
            if (fidx == 3) begin
                flen = int'(d);
                if (fsrc >= 0 && fsrc < N && q_len[fsrc].size() > 0) void'(q_len[fsrc].pop_front());
            end
            fidx++;
            if (fidx >= 5 && fidx == flen + 5) begin
                fidx = 0;
                frames_done++;
                grants.push_back(fsrc);
            end
        end
        for (int i = 0; i < N; i++)
            if (rq[i] && q_pay[i].size() > 0) void'(q_pay[i].pop_front());
        case (rmode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
        drive_inputs();
    endtask

    task automatic run(input string nm, input int budget);
        int c = 0;
        while ((frames_done < exp_frames || state != 3'd0) && c < budget) begin
            cycle();
            c++;
        end
        if (c >= budget) budget_fail(nm);
        cycle();
    endtask

    task automatic check_stream(input string nm);
        chk({nm, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk({nm, "_byte"}, int'(rx_q[i]), int'(exp_q[i]));
            if (rx_q[i] != exp_q[i]) break;
        end
        chk({nm, "_rdreq_count"}, rd_cnt, exp_rd);
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        mdl_ptr = 0;
        drive_inputs();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[$];
        int exp_g[4];
        int c;
        vt[0] = '{src: 0, len: 1, b0: 8'hA5, rmode: 0, exp_crc: 8'h71};
        vt[1] = '{src: 0, len: 0, b0: 8'h00, rmode: 0, exp_crc: 8'h6B};
        vt[2] = '{src: 0, len: 1, b0: 8'hA5, rmode: 1, exp_crc: 8'h71};
`ifdef TX_RR_ARB_EN
        exp_g = '{0, 2, 0, 2};
`else
        exp_g = '{0, 0, 0, 2};
`endif
        n_rst = 1'b0; tx_ready = 1'b1; rmode = 0; mdl_ptr = 0;
        flush_sources(); clear_mon(); drive_inputs();
        #3;
        chk("reset_state", int'(state), 0);
        chk("reset_tx_valid", int'(tx_valid), 0);
        chk("reset_tx_data", int'(tx_data), 0);
        chk("reset_rdreq", int'(rdreq_bus), 0);
        chk("reset_current_source", int'(current_source), 0);
        chk("reset_crc", int'(crc), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 3; t++) begin
            clear_mon();
            rmode = vt[t].rmode;
            tx_ready = 1'b1;
            load_msg(vt[t].src, vt[t].len, vt[t].b0, 0);
            build_expected();
            drive_inputs();
            cycle();
            chk("first_byte_state", int'(state), 1);
            chk("first_byte_valid", int'(tx_valid), 1);
            chk("first_byte_data", int'(tx_data), 8'hDD);
            run("table_frame", 200);
            check_stream("table");
            chk("table_transfers", rx_q.size(), vt[t].len + 5);
            if (rx_q.size() > 0) chk("table_crc", int'(rx_q[rx_q.size() - 1]), int'(vt[t].exp_crc));
            exp_seq = '{1, 2, 3, 4};
            if (vt[t].len > 0) exp_seq.push_back(5);
            exp_seq.push_back(6);
            exp_seq.push_back(0);
            chk("state_seq_len", st_log.size(), exp_seq.size());
            for (int i = 0; i < exp_seq.size() && i < st_log.size(); i++)
                chk("state_seq", st_log[i], exp_seq[i]);
        end

        // Source 1, six bytes; have/len drop once its length has been sent.
        clear_mon();
        rmode = 2;
        load_msg(1, 6, 8'h00, 1);
        build_expected();
        drive_inputs();
        run("midframe", 300);
        check_stream("midframe");

        apply_reset();
        rmode = 0;
        for (int m = 0; m < 3; m++) begin
            load_msg(0, 1, 8'h30 + 8'(m), 0);
            load_msg(2, 1, 8'h50 + 8'(m), 0);
        end
        build_expected();
        drive_inputs();
        run("arbitration", 300);
        check_stream("arbitration");
        chk("grant_count", grants.size(), 6);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            chk("grant_order", grants[i], exp_g[i]);

        for (int r = 0; r < 4; r++) begin
            clear_mon();
            rmode = 2;
            for (int s = 0; s < N; s++) begin
                c = $urandom_range(0, 2);
                for (int m = 0; m < c; m++) load_msg(s, $urandom_range(0, 6), 8'h00, 1);
            end
            build_expected();
            drive_inputs();
            run("random", 2000);
            check_stream("random");
        end

        // Abort mid-payload, then confirm a clean fresh frame.
        clear_mon();
        rmode = 0;
        tx_ready = 1'b1;
        load_msg(1, 6, 8'h00, 1);
        drive_inputs();
        c = 0;
        while (state != 3'd5 && c < 40) begin
            cycle();
            c++;
        end
        if (c >= 40) budget_fail("abort_reach_payload");
        cycle();
        n_rst = 1'b0;
        #1;
        chk("abort_state", int'(state), 0);
        chk("abort_tx_valid", int'(tx_valid), 0);
        chk("abort_tx_data", int'(tx_data), 0);
        chk("abort_rdreq", int'(rdreq_bus), 0);
        chk("abort_crc", int'(crc), 0);
        chk("abort_current_source", int'(current_source), 0);
        flush_sources();
        apply_reset();
        load_msg(0, 1, 8'hA5, 0);
        build_expected();
        drive_inputs();
        run("after_abort", 200);
        if (rx_q.size() > 0) chk("after_abort_prefix", int'(rx_q[0]), 8'hDD);
        check_stream("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_packet_scheduler.md
Name: tx_packet_scheduler

Overview:
- Shares the single UART transmitter among NUM_SOURCES message FIFOs.
- Arbitrates between sources that have a complete message pending and grants one source per packet.
- Frames the granted message as: prefix 0xDD, source address, destination, length, payload, CRC-8.
- Streams the frame byte-wise over a valid/ready handshake into the UART tx; sits between the source FIFOs and the UART tx in the bos top level.

Parameters:
- NUM_SOURCES, `NUM_SOURCES, number of requesting source FIFOs (1..8).
- PREFIX, 8'hDD, first byte of every frame.
- SRC_BASE, 8'h01, source address byte is SRC_BASE + granted index.
- DEST_ADDR, 8'h00, destination byte (host).

Ports:
- clk  input  1  system clock, 48 MHz.
- n_rst  input  1  asynchronous active-low reset.
- have_msg_bus  input  NUM_SOURCES  bit i high: source i holds at least one complete message.
- len_bus  input  8*NUM_SOURCES  payload length of source i's head message, bits [8i+7:8i].
- data_bus  input  8*NUM_SOURCES  show-ahead head byte of source i.
- rdreq_bus  output  NUM_SOURCES  one-cycle pop strobe to source i.
- tx_data  output  8  byte to UART tx.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART tx accepts a byte this cycle.
- current_source  output  3  granted/last granted index (debug).
- state  output  3  FSM state encoding (debug).
- crc  output  8  running CRC (debug).

Behaviour:
- Reset (async, n_rst=0): state=IDLE, tx_valid=0, tx_data=0, rdreq_bus=0, current_source=0, crc=0, internal byte counter=0, round-robin pointer=0.
- Transfer rule: a byte moves when tx_valid&&tx_ready at a rising edge. While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid is never deasserted mid-frame without a transfer.
- FSM encoding: IDLE=0, PREFIX=1, SRC=2, DEST=3, LEN=4, PAYLOAD=5, CRC=6. The state output equals this encoding.
- IDLE: when any have_msg_bus bit is set, the grant is decided combinationally. On the next edge:
  - current_source latches the winner.
  - len_bus for the winner is latched into an 8-bit counter.
  - crc clears to 0x00.
  - state goes to PREFIX with tx_valid=1 and tx_data=PREFIX, so the first byte is presented one cycle after the request is seen.
- PREFIX→SRC→DEST→LEN: each advances on its transfer. tx_data for each state is SRC_BASE+current_source, DEST_ADDR and the latched length, respectively.
- LEN→PAYLOAD on transfer when length≠0. When length=0, LEN goes to CRC directly.
- PAYLOAD: tx_data = data_bus byte of current_source.
  - On each transfer, rdreq_bus[current_source] pulses for exactly that cycle and the counter decrements.
  - The transfer of the last byte (counter=1) moves to CRC.
- CRC: tx_data = crc. On transfer, tx_valid drops and state goes to IDLE. The rdreq pulse of the final payload byte and the CRC presentation never overlap.
- CRC definition: CRC-8, polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Covers SRC, DEST, LEN and payload bytes; the prefix is excluded.
  - Updated combinationally on each accepted byte and registered on the transfer edge.
- Grant is fixed for the whole frame. Changes on have_msg_bus or len_bus mid-frame are ignored.
- Back-to-back: IDLE lasts at least one cycle between frames, and arbitration runs only in IDLE.
- Only rdreq_bus[current_source] can ever be high, and only in PAYLOAD.
- Reset asserted mid-frame aborts immediately: no further rdreq, and the partial frame is not resumed.

Optional Feature:
- Macro: TX_RR_ARB_EN.
- Defined: round-robin arbitration. The search starts at index (last granted + 1) mod NUM_SOURCES, and the pointer updates at each grant.
- Undefined: fixed priority, lowest set index wins; the pointer logic is absent.

Test Plan:
- Single frame: source 0 requests with len=1, head byte 0xA5, tx_ready=1 → tx stream DD 01 00 01 A5 71. rdreq_bus[0] pulses once, on the A5 transfer. Then IDLE.
- Zero length: source 0 requests with len=0 → DD 01 00 00 then CRC; state sequence 1,2,3,4,6,0; rdreq_bus never asserted.
- Backpressure: repeat the first frame with tx_ready toggling 1/0 each cycle → identical byte sequence, tx_data stable while not ready, exactly 6 transfers.
- Arbitration: sources 0 and 2 both request continuously, each sending single-byte frames:
  - With TX_RR_ARB_EN: grants go 0,2,0,2.
  - Without TX_RR_ARB_EN: grants go 0,0,0 while source 0 keeps requesting.
- Mid-frame changes: source 1 is granted with len=6 and have_msg_bus[1] drops during PAYLOAD → all 6 payload bytes are sent, 6 rdreq pulses, correct CRC.
- Reset abort: n_rst pulsed low in PAYLOAD → outputs return to reset values immediately. After release, a new request starts a fresh frame with prefix DD.
